// File: rtl/dsp_simd_unpack_v3.sv
// Unpacks a 48-bit DSP SIMD result word (12-bit lane slots) into a stream of scalar lanes, lane 0 first.
// Optional sign-extension check on the ignored upper lane bits: define DSP_SIMD_UNPACK_SIGN_CHECK_EN.
module dsp_simd_unpack_v3 #(
  parameter int width = 12,
  parameter int lanes = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
  ,
  output logic             out_err
`endif
);

  if (width < 1 || width > 12) begin : g_bad_width
    $error("dsp_simd_unpack_v3: width must be in 1..12");
  end
  if (lanes < 1 || lanes > 4) begin : g_bad_lanes
    $error("dsp_simd_unpack_v3: lanes must be in 1..4");
  end

  localparam logic [1:0] LAST_IDX = 2'(lanes - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [47:0] word_buf;
  logic [1:0]  idx;
  logic [11:0] lane_word;
  logic        at_last;

  always_comb begin
    lane_word = word_buf[11:0];
    case (idx)
      2'd1:    lane_word = word_buf[23:12];
      2'd2:    lane_word = word_buf[35:24];
      2'd3:    lane_word = word_buf[47:36];
      default: lane_word = word_buf[11:0];
    endcase
  end

  assign at_last   = (idx == LAST_IDX);
  assign out_valid = (state == EMIT);
  assign out_data  = lane_word[width-1:0];
  assign out_lane  = idx;
  assign out_last  = out_valid && at_last;
  // The only input-to-output combinational path: out_ready -> in_ready on the last lane.
  assign in_ready  = (state == IDLE) || (out_ready && at_last);

`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
  logic sext_bad;
  if (width < 12) begin : g_sext
    assign sext_bad = (lane_word[11:width] != {(12-width){lane_word[width-1]}});
  end else begin : g_no_sext
    assign sext_bad = 1'b0;
  end
  assign out_err = out_valid && sext_bad;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 2'd0;
      word_buf <= 48'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_buf <= in_data;
            idx      <= 2'd0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!at_last) begin
              idx <= idx + 2'd1;
            end else begin
              idx <= 2'd0;
              if (in_valid) begin
                word_buf <= in_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_simd_unpack_v3.sv
// Bench for dsp_simd_unpack_v3: directed vector table, hand-written corner sequences,
// and randomized traffic against a lane-queue reference model.
module tb_dsp_simd_unpack_v3;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [47:0] a_in_data;
  logic [11:0] a_out_data;
  logic [1:0]  a_out_lane;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [47:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_lane;
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
  logic        a_out_err, b_out_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dsp_simd_unpack_v3 #(.width(12), .lanes(3)) u_a (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_lane(a_out_lane), .out_last(a_out_last)
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
    , .out_err(a_out_err)
`endif
  );

  dsp_simd_unpack_v3 #(.width(8), .lanes(2)) u_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_lane(b_out_lane), .out_last(b_out_last)
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
    , .out_err(b_out_err)
`endif
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [47:0] din;
    logic        ordy;
    logic        ev;
    logic        erdy;
    logic [11:0] edata;
    logic [1:0]  elane;
    logic        elast;
    logic        cd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic iv, input logic [47:0] din, input logic ordy,
                      input logic ev, input logic erdy, input logic [11:0] edata,
                      input logic [1:0] elane, input logic elast, input logic cd);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.ev = ev; v.erdy = erdy;
    v.edata = edata; v.elane = elane; v.elast = elast; v.cd = cd;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [11:0] data;
    logic [1:0]  lane;
    logic        last;
  } lane_t;

  lane_t model_q[$];

  localparam logic [47:0] W1 = 48'h000_ABC_456_123;
  localparam logic [47:0] WA = 48'h000_003_002_001;
  localparam logic [47:0] WB = 48'h000_006_005_004;

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset then idle
    for (int i = 0; i < 5; i++) addv(0, '0, 1, 0, 1, 12'h000, 0, 0, 1);
    // single word, full-rate drain
    addv(1, W1, 1, 0, 1, 12'h000, 0, 0, 1);
    addv(0, '0, 1, 1, 0, 12'h123, 0, 0, 1);
    addv(0, '0, 1, 1, 0, 12'h456, 1, 0, 1);
    addv(0, '0, 1, 1, 1, 12'hABC, 2, 1, 1);
    addv(0, '0, 1, 0, 1, 12'h000, 0, 0, 0);
    // back-to-back; B offered early must wait for the last lane of A
    addv(1, WA, 1, 0, 1, 12'h000, 0, 0, 0);
    addv(1, WB, 1, 1, 0, 12'h001, 0, 0, 1);
    addv(1, WB, 1, 1, 0, 12'h002, 1, 0, 1);
    addv(1, WB, 1, 1, 1, 12'h003, 2, 1, 1);
    addv(0, '0, 1, 1, 0, 12'h004, 0, 0, 1);
    addv(0, '0, 1, 1, 0, 12'h005, 1, 0, 1);
    addv(0, '0, 1, 1, 1, 12'h006, 2, 1, 1);
    addv(0, '0, 1, 0, 1, 12'h000, 0, 0, 0);
    // backpressure on lane 1 for 4 cycles
    addv(1, WA, 1, 0, 1, 12'h000, 0, 0, 0);
    addv(0, '0, 1, 1, 0, 12'h001, 0, 0, 1);
    for (int i = 0; i < 4; i++) addv(0, '0, 0, 1, 0, 12'h002, 1, 0, 1);
    addv(0, '0, 1, 1, 0, 12'h002, 1, 0, 1);
    addv(0, '0, 1, 1, 1, 12'h003, 2, 1, 1);
    addv(0, '0, 1, 0, 1, 12'h000, 0, 0, 0);

    foreach (tbl[k]) begin
      a_in_valid = tbl[k].iv; a_in_data = tbl[k].din; a_out_ready = tbl[k].ordy;
      #1;
      check($sformatf("tbl%0d out_valid", k), 48'(a_out_valid), 48'(tbl[k].ev));
      check($sformatf("tbl%0d in_ready", k), 48'(a_in_ready), 48'(tbl[k].erdy));
      if (tbl[k].cd) begin
        check($sformatf("tbl%0d out_data", k), 48'(a_out_data), 48'(tbl[k].edata));
        check($sformatf("tbl%0d out_lane", k), 48'(a_out_lane), 48'(tbl[k].elane));
        check($sformatf("tbl%0d out_last", k), 48'(a_out_last), 48'(tbl[k].elast));
      end
      @(negedge clock);
    end

    // reset while lane 1 is presented, with a coincident in_valid that must be dropped
    a_in_valid = 1'b1; a_in_data = WA; a_out_ready = 1'b1;
    @(negedge clock);
    a_in_valid = 1'b0;
    @(negedge clock);
    #1 check("rst_mid pre lane", 48'(a_out_lane), 48'd1);
    reset = 1'b1; a_in_valid = 1'b1; a_in_data = WB;
    @(negedge clock);
    reset = 1'b0; a_in_valid = 1'b0;
    #1;
    check("rst_mid out_valid", 48'(a_out_valid), 48'd0);
    check("rst_mid in_ready", 48'(a_in_ready), 48'd1);
    @(negedge clock);
    #1 check("rst_mid dropped word", 48'(a_out_valid), 48'd0);
    a_in_valid = 1'b1; a_in_data = W1;
    @(negedge clock);
    a_in_valid = 1'b0;
    #1;
    check("rst_mid lane0 data", 48'(a_out_data), 48'h123);
    check("rst_mid lane0 lane", 48'(a_out_lane), 48'd0);
    repeat (3) @(negedge clock);
    #1 check("rst_mid drained", 48'(a_out_valid), 48'd0);
    @(negedge clock);

    // randomized traffic against the lane-queue model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic fire_in, fire_out, exp_rdy;
      a_in_valid  = ($urandom_range(0, 99) < 60);
      a_in_data   = {16'($urandom), $urandom};
      a_out_ready = ($urandom_range(0, 99) < 70);
      #1;
      exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && a_out_ready);
      check("rnd out_valid", 48'(a_out_valid), 48'(model_q.size() != 0));
      check("rnd in_ready", 48'(a_in_ready), 48'(exp_rdy));
      if (model_q.size() != 0) begin
        check("rnd out_data", 48'(a_out_data), 48'(model_q[0].data));
        check("rnd out_lane", 48'(a_out_lane), 48'(model_q[0].lane));
        check("rnd out_last", 48'(a_out_last), 48'(model_q[0].last));
      end
      fire_out = (model_q.size() != 0) && a_out_ready;
      fire_in  = a_in_valid && exp_rdy;
      if (fire_out) void'(model_q.pop_front());
      if (fire_in) begin
        for (int l = 0; l < 3; l++) begin
          lane_t e;
          e.data = 12'((a_in_data >> (12 * l)) & 48'hFFF);
          e.lane = 2'(l);
          e.last = (l == 2);
          model_q.push_back(e);
        end
      end
      @(negedge clock);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;

    // width 8, lanes 2: upper nibbles and bits above lane 1 ignored
    b_in_valid = 1'b1; b_in_data = 48'hABC_DEF_FF7_E12;
    #1 check("w8 idle in_ready", 48'(b_in_ready), 48'd1);
    @(negedge clock);
    b_in_valid = 1'b0;
    #1;
    check("w8 lane0 data", 48'(b_out_data), 48'h12);
    check("w8 lane0 last", 48'(b_out_last), 48'd0);
    check("w8 lane0 in_ready", 48'(b_in_ready), 48'd0);
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
    check("w8 lane0 err", 48'(b_out_err), 48'd1);
`endif
    @(negedge clock);
    #1;
    check("w8 lane1 data", 48'(b_out_data), 48'hF7);
    check("w8 lane1 lane", 48'(b_out_lane), 48'd1);
    check("w8 lane1 last", 48'(b_out_last), 48'd1);
    check("w8 lane1 in_ready", 48'(b_in_ready), 48'd1);
`ifdef DSP_SIMD_UNPACK_SIGN_CHECK_EN
    check("w8 lane1 err", 48'(b_out_err), 48'd0);
`endif
    @(negedge clock);
    #1 check("w8 done out_valid", 48'(b_out_valid), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
